// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator/link execution stage:
// default datapath width, state/phase encoding and micro-op bit positions
// (positions match the group-1 operate instruction bits).
package acc_pkg;

    localparam int unsigned WIDTH = 12;
    localparam int unsigned UOP_W = 8;

    localparam int unsigned UOP_CLA = 7;
    localparam int unsigned UOP_CLC = 6;
    localparam int unsigned UOP_CMA = 5;
    localparam int unsigned UOP_CMC = 4;
    localparam int unsigned UOP_RAR = 3;
    localparam int unsigned UOP_RAL = 2;
    localparam int unsigned UOP_ROT = 1;
    localparam int unsigned UOP_IAC = 0;

    // Phase order is the numeric order; next-phase selection relies on it.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        P_CLR  = 3'd1,
        P_CMP  = 3'd2,
        P_INC  = 3'd3,
        P_ROT1 = 3'd4,
        P_ROT2 = 3'd5,
        DONE   = 3'd6
    } state_e;

endpackage

// File: rtl/acc_link_unit_if.sv
// Controller <-> accumulator/link stage interface.
// master: controller side (drives loads, start and micro-op selects).
// slave : execution stage (drives ACC/link, status flags, busy/done/load_err).
interface acc_link_unit_if #(
    parameter int unsigned WIDTH = acc_pkg::WIDTH
);
    logic [WIDTH-1:0] acc_in;
    logic             cy_in;
    logic             acc_write;
    logic             cy_write;
    logic             opr_start;
    logic             uop_cla;
    logic             uop_clc;
    logic             uop_cma;
    logic             uop_cmc;
    logic             uop_rar;
    logic             uop_ral;
    logic             uop_rot;
    logic             uop_iac;

    logic [WIDTH-1:0] acc_out;
    logic             link_out;
    logic             acc_zero;
    logic             acc_neg;
    logic             cy_zero;
    logic             busy;
    logic             done;
    logic             load_err;

    modport master (
        output acc_in, cy_in, acc_write, cy_write, opr_start,
               uop_cla, uop_clc, uop_cma, uop_cmc, uop_rar, uop_ral, uop_rot, uop_iac,
        input  acc_out, link_out, acc_zero, acc_neg, cy_zero, busy, done, load_err
    );

    modport slave (
        input  acc_in, cy_in, acc_write, cy_write, opr_start,
               uop_cla, uop_clc, uop_cma, uop_cmc, uop_rar, uop_ral, uop_rot, uop_iac,
        output acc_out, link_out, acc_zero, acc_neg, cy_zero, busy, done, load_err
    );
endinterface

// File: rtl/acc_link_unit_link_rotator.sv
// Rotates the combined {link, ACC} word one place.
// Ports: vec (in, {link,ACC}), right (in, 1 = rotate right, 0 = left),
//        rot_c (out, rotated word, combinational).
module link_rotator #(
    parameter int unsigned WIDTH = acc_pkg::WIDTH
) (
    input  logic [WIDTH:0] vec,
    input  logic           right,
    output logic [WIDTH:0] rot_c
);
    // Right: ACC[0] -> link, link -> ACC[MSB]. Left is the mirror.
    always_comb begin
        rot_c = vec;
        if (right) begin
            rot_c = {vec[0], vec[WIDTH:1]};
        end else begin
            rot_c = {vec[WIDTH-1:0], vec[WIDTH]};
        end
    end
endmodule

// File: rtl/acc_link_unit.sv
// Accumulator/link execution stage. Holds ACC and link, applies controller
// loads in IDLE and runs group-1 operate micro-ops as a fixed phase sequence
// (CLR, CMP, INC, ROT1, ROT2), skipping inactive phases.
// Ports: clk, rst (async, active-low), bus (slave side of acc_link_unit_if):
//   loads/start/uop selects in; ACC, link, zero/neg/carry flags, busy, done,
//   load_err out.
module acc_link_unit
    import acc_pkg::*;
#(
    parameter int unsigned WIDTH = acc_pkg::WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    acc_link_unit_if.slave    bus
);

    state_e           state_q, state_n;
    logic [WIDTH-1:0] acc_q, acc_n;
    logic             link_q, link_n;
    logic [UOP_W-1:0] uop_q, uop_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic             load_err_q, load_err_n;

    logic [UOP_W-1:0] uop_in;
    logic             load_req;
    logic [WIDTH:0]   rot_c;

    // First active phase strictly after 'cur'; DONE when none remain.
    function automatic state_e next_after(state_e cur, logic [UOP_W-1:0] u);
        logic rot1;
        rot1 = u[UOP_RAR] ^ u[UOP_RAL];
        if (cur < P_CLR && (u[UOP_CLA] || u[UOP_CLC])) return P_CLR;
        if (cur < P_CMP && (u[UOP_CMA] || u[UOP_CMC])) return P_CMP;
        if (cur < P_INC && u[UOP_IAC]) return P_INC;
        if (cur < P_ROT1 && rot1) return P_ROT1;
        if (cur < P_ROT2 && rot1 && u[UOP_ROT]) return P_ROT2;
        return DONE;
    endfunction

    assign uop_in = {bus.uop_cla, bus.uop_clc, bus.uop_cma, bus.uop_cmc,
                     bus.uop_rar, bus.uop_ral, bus.uop_rot, bus.uop_iac};
    assign load_req = bus.acc_write || bus.cy_write;

    link_rotator #(.WIDTH(WIDTH)) u_rot (
        .vec   ({link_q, acc_q}),
        .right (uop_q[UOP_RAR]),
        .rot_c (rot_c)
    );

    // Next state, datapath updates and registered status pulses.
    always_comb begin
        state_n    = state_q;
        acc_n      = acc_q;
        link_n     = link_q;
        uop_n      = uop_q;
        load_err_n = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A load wins over a coincident start; the start is dropped.
                if (load_req) begin
                    if (bus.acc_write) acc_n  = bus.acc_in;
                    if (bus.cy_write)  link_n = bus.cy_in;
                end else if (bus.opr_start) begin
                    uop_n   = uop_in;
                    state_n = next_after(IDLE, uop_in);
                end
            end
            P_CLR: begin
                if (uop_q[UOP_CLA]) acc_n  = '0;
                if (uop_q[UOP_CLC]) link_n = 1'b0;
                state_n = next_after(P_CLR, uop_q);
            end
            P_CMP: begin
                if (uop_q[UOP_CMA]) acc_n  = ~acc_q;
                if (uop_q[UOP_CMC]) link_n = ~link_q;
                state_n = next_after(P_CMP, uop_q);
            end
            P_INC: begin
                {link_n, acc_n} = {link_q, acc_q} + (WIDTH+1)'(1);
                state_n = next_after(P_INC, uop_q);
            end
            P_ROT1: begin
                {link_n, acc_n} = rot_c;
                state_n = next_after(P_ROT1, uop_q);
            end
            P_ROT2: begin
                {link_n, acc_n} = rot_c;
                state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (state_q != IDLE && load_req) load_err_n = 1'b1;

        busy_n = (state_n != IDLE) && (state_n != DONE);
        done_n = (state_n == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            link_q     <= 1'b0;
            uop_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            acc_q      <= acc_n;
            link_q     <= link_n;
            uop_q      <= uop_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            load_err_q <= load_err_n;
        end
    end

    assign bus.acc_out  = acc_q;
    assign bus.link_out = link_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.load_err = load_err_q;

    // Status flags are zero-latency decodes of the registers.
    assign bus.acc_zero = (acc_q == '0);
    assign bus.acc_neg  = acc_q[WIDTH-1];
    assign bus.cy_zero  = ~link_q;

endmodule

// File: doc/acc_link_unit.md
Name: acc_link_unit

Overview:
- Accumulator/link execution stage directly downstream of the multicycle controller.
- Consumes the controller's micro-op strobes (cla, clc, cma, cmc, rar, ral, rot, iac) and its acc_write/cy_write load strobes.
- Holds the 12-bit ACC and the 1-bit link (carry). Executes group-1 operate micro-ops in a fixed phase sequence.
- Returns the acc_zero, acc_neg and cy_zero status flags to the controller for skip decisions.

Parameters:
- WIDTH, 12, accumulator width in bits; link is always 1 bit.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- acc_in  in  WIDTH  ALU result to load into ACC.
- cy_in  in  1  ALU carry to load into link.
- acc_write  in  1  load ACC from acc_in.
- cy_write  in  1  load link from cy_in.
- opr_start  in  1  start an operate sequence using the uop_* bits sampled in the same cycle.
- uop_cla, uop_clc, uop_cma, uop_cmc, uop_rar, uop_ral, uop_rot, uop_iac  in  1 each  micro-op selects.
- acc_out  out  WIDTH  current ACC.
- link_out  out  1  current link.
- acc_zero  out  1  ACC equals 0.
- acc_neg  out  1  ACC[WIDTH-1].
- cy_zero  out  1  link equals 0.
- busy  out  1  operate sequence in progress.
- done  out  1  one-cycle pulse when a sequence completes.
- load_err  out  1  one-cycle pulse when a load is attempted while not IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - ACC = 0, link = 0, state = IDLE, latched uops = 0.
  - busy = 0, done = 0, load_err = 0.
  - Flags follow the registers: acc_zero = 1, acc_neg = 0, cy_zero = 1.
  - Reset mid-sequence aborts the sequence; no partial result is kept.
- Flags are purely combinational from the registers (zero-latency). They reflect updates the cycle after the edge that made them.
- Loads:
  - Accepted in IDLE only. acc_write and cy_write act independently on the same edge.
  - In any non-IDLE state a load is ignored and load_err pulses on the next cycle.
  - In IDLE, a load has priority over opr_start: the start is dropped and no sequence begins.
- Start:
  - opr_start in IDLE with no load latches the uop bits.
  - The next state is the first active phase, or DONE if no phase is active.
  - opr_start outside IDLE is ignored. The uop inputs are don't-care after the latch.
- Phases, in fixed order. Each active phase occupies one cycle (busy = 1) and updates the registers at its closing edge. Inactive phases are skipped.
  - P_CLR, active if cla or clc: cla clears ACC; clc clears link.
  - P_CMP, active if cma or cmc: cma inverts ACC; cmc inverts link.
  - P_INC, active if iac: {link,ACC} := ({link,ACC} + 1) mod 2^(WIDTH+1). The carry out of ACC toggles link.
  - P_ROT1, active if exactly one of rar/ral is set: rotate the 13-bit {link,ACC} one place.
    - rar: link goes to ACC[11], ACC[0] goes to link.
    - ral: the mirror of rar.
  - P_ROT2, active if P_ROT1 is active and rot = 1: a second identical rotate.
  - rar and ral both set: no rotate. rot with neither set: no rotate.
- Completion:
  - DONE lasts one cycle: done = 1, busy = 0. The next state is IDLE.
  - With start sampled at edge T and N active phases, done is high in cycle T+1+N. For N = 0, done is high in cycle T+1.
- Encoding: the state register is 3-bit binary: IDLE, P_CLR, P_CMP, P_INC, P_ROT1, P_ROT2, DONE.

Decomposition:
- Shared package acc_pkg holds:
  - WIDTH default;
  - the state/phase enum;
  - the uop bit-index constants, matching instruction bits cla=7, clc=6, cma=5, cmc=4, rar=3, ral=2, rot=1, iac=0.
- One natural combinational sub-module: link_rotator, which rotates {link,ACC} one place left or right.
- The next-active-phase selection stays in acc_link_unit.

Test Plan:
- Reset: release rst with no other stimulus -> acc_out=0x000, link_out=0, acc_zero=1, cy_zero=1, busy=0.
- Complement and increment: load ACC=0x005, link=0; start cma+iac -> after 2 busy cycles ACC=0xFFB, link=0, done pulses at T+3, acc_neg=1.
- All clear/complement/increment ops: start cla+clc+cma+cmc+iac from ACC=0x123, link=0 -> after P_CLR ACC=0x000, link=0; after P_CMP ACC=0xFFF, link=1; after P_INC ACC=0x000, link=0 (wrap); acc_zero=1; done at T+4.
- Double rotate left: ACC=0x801, link=0; start ral+rot -> after P_ROT1 link=1, ACC=0x002; after P_ROT2 link=0, ACC=0x005; done at T+3.
- Degenerate selects: start with no uops -> done at T+1, registers unchanged. Start rar+ral -> no rotation, done at T+1.
- Collisions:
  - assert acc_write with acc_in=0x777 during P_CMP -> load_err pulses, ACC unaffected by the load;
  - in IDLE, assert opr_start together with acc_write (acc_in=0x010) -> ACC=0x010, no busy, no done;
  - assert rst low during P_INC -> ACC=0, link=0, state IDLE immediately.
